exhaustive_sweeper: RTL and testbench

Self-running exhaustive stimulus and response checker for small combinational blocks in the lab designs. It walks every input combination of an `IN_W`-bit design under test and holds each vector for a programmable dwell time. At the end of each dwell it samples the DUT outputs, compares them against a reference model, and folds them into a MISR signature. It sits between a lab block and its reference model, so a bench only issues `start` and reads the results after `done`.

---
 rtl/exhaustive_sweeper_pkg.sv | 18 +
 rtl/exhaustive_sweeper_misr.sv | 42 ++++
 rtl/exhaustive_sweeper.sv | 134 +++++++++++++
 tb/tb_exhaustive_sweeper.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exhaustive_sweeper_pkg.sv
// Shared types and helpers for the exhaustive stimulus sweeper.
// Holds the sweep FSM encoding, the default MISR taps and the Gray encoder.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h002D;

  // Width-agnostic: callers truncate the result to their own vector width.
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/exhaustive_sweeper_misr.sv
// Multiple-input signature register folding OUT_W response bits per sample.
// Feedback is a left shift with POLY applied when the outgoing MSB is set.
module misr
  import sweeper_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter int unsigned      OUT_W = 2,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_ext;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_next;

  always_comb begin
    w_ext              = '0;
    w_ext[OUT_W-1:0]   = din;
    w_fb               = r_sig[SIG_W-1] ? POLY : '0;
    w_next             = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ w_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/exhaustive_sweeper.sv
// Walks every IN_W-bit input vector, holds each for DWELL cycles, then compares
// the DUT against its reference model and folds the DUT response into a MISR.
module exhaustive_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned      IN_W  = 4,
  parameter int unsigned      OUT_W = 2,
  parameter int unsigned      DWELL = 20,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gray_mode,
  output logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    err_cnt,
  output logic             first_err_valid,
  output logic [IN_W-1:0]  first_err_vec,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned DW_W = $clog2(DWELL);

  state_t          r_state;
  state_t          w_next;
  logic [IN_W-1:0] r_idx;
  logic [DW_W-1:0] r_dwell;
  logic            r_gray;
  logic [IN_W:0]   r_err_cnt;
  logic            r_fev;
  logic [IN_W-1:0] r_fevec;

  logic            w_busy;
  logic            w_done;
  logic            w_accept;
  logic            w_sample;
  logic            w_last;
  logic            w_mismatch;
  logic [IN_W-1:0] w_vec;

  assign w_last     = (r_idx == '1);
  assign w_mismatch = (dut_out != exp_out);
  assign w_vec      = r_gray ? IN_W'(gray_enc(32'(r_idx))) : r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_sample && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == RUN);
    w_done   = (r_state == DONE);
    w_accept = (r_state == IDLE) && start;
    w_sample = w_busy && (r_dwell == DW_W'(DWELL - 1));
  end

  // Terminal sample leaves idx on the last vector so vec holds through DONE;
  // idx only returns to 0 as the FSM drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_dwell   <= '0;
      r_gray    <= 1'b0;
      r_err_cnt <= '0;
      r_fev     <= 1'b0;
      r_fevec   <= '0;
    end else if (w_accept) begin
      r_idx     <= '0;
      r_dwell   <= '0;
      r_gray    <= gray_mode;
      r_err_cnt <= '0;
      r_fev     <= 1'b0;
      r_fevec   <= '0;
    end else if (w_busy) begin
      if (w_sample) begin
        r_dwell <= '0;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_fev) begin
            r_fev   <= 1'b1;
            r_fevec <= w_vec;
          end
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end else if (w_done) begin
      r_idx   <= '0;
      r_dwell <= '0;
    end
  end

  misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_sample),
    .din   (dut_out),
    .sig   (signature)
  );

  assign vec             = w_vec;
  assign busy            = w_busy;
  assign done            = w_done;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_fev;
  assign first_err_vec   = r_fevec;

endmodule

// File: tb/tb_exhaustive_sweeper.sv
// Directed bench for exhaustive_sweeper: default 4-bit instance plus a tiny
// 2-bit instance used for a hand-worked signature.
module tb_exhaustive_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gray_mode = 1'b0;
  logic [3:0]  vec;
  logic [1:0]  dut_out;
  logic [1:0]  exp_out;
  logic        busy;
  logic        done;
  logic [4:0]  err_cnt;
  logic        fev;
  logic [3:0]  fevec;
  logic [15:0] signature;

  logic        start2 = 1'b0;
  logic        gray2 = 1'b0;
  logic [1:0]  vec2;
  logic        dut2;
  logic        exp2;
  logic        busy2;
  logic        done2;
  logic [2:0]  err2;
  logic        fev2;
  logic [1:0]  fevec2;
  logic [3:0]  sig2;

  // 0: clean, 1: flip at 5 and 9, 2: flip at 9 and 12, 3: flip everywhere
  logic [1:0]  fault_mode = 2'd0;
  logic        flip;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] seq [16];
  int         busy_len;
  int         hold_bad;
  int         done_total;
  logic       done_at_end;
  logic [4:0] err_at_done;

  always #5 clk = ~clk;

  assign flip = (fault_mode == 2'd1 && (vec == 4'd5 || vec == 4'd9)) ||
                (fault_mode == 2'd2 && (vec == 4'd9 || vec == 4'd12)) ||
                (fault_mode == 2'd3);
  assign dut_out = vec[1:0];
  assign exp_out = flip ? ~vec[1:0] : vec[1:0];
  assign dut2 = 1'b1;
  assign exp2 = 1'b1;

  exhaustive_sweeper u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .gray_mode       (gray_mode),
    .vec             (vec),
    .dut_out         (dut_out),
    .exp_out         (exp_out),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .first_err_valid (fev),
    .first_err_vec   (fevec),
    .signature       (signature)
  );

  exhaustive_sweeper #(
    .IN_W  (2),
    .OUT_W (1),
    .DWELL (2),
    .SIG_W (4),
    .POLY  (4'h3)
  ) u_small (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start2),
    .gray_mode       (gray2),
    .vec             (vec2),
    .dut_out         (dut2),
    .exp_out         (exp2),
    .busy            (busy2),
    .done            (done2),
    .err_cnt         (err2),
    .first_err_valid (fev2),
    .first_err_vec   (fevec2),
    .signature       (sig2)
  );

  // Stimulus only: launches a sweep and records what the DUT did.
  task automatic run_sweep(input logic gm, input bit poke_start);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    gray_mode = gm;
    @(negedge clk);
    start = 1'b0;
    gray_mode = ~gm;
    busy_len = 0;
    hold_bad = 0;
    done_total = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      if (cyc / 20 < 16) begin
        if (cyc % 20 == 0) seq[cyc/20] = vec;
        else if (vec !== seq[cyc/20]) hold_bad++;
      end
      if (done === 1'b1) done_total++;
      busy_len++;
      cyc++;
      start = poke_start && (cyc == 100);
      @(negedge clk);
    end
    start = 1'b0;
    done_at_end = done;
    err_at_done = err_cnt;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_total++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({vec, busy, done} !== 6'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {vec, busy, done});
    end
    n_checks++;
    if ({err_cnt, fev, fevec} !== 10'd0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", {err_cnt, fev, fevec});
    end
    n_checks++;
    if (signature !== 16'h0000) begin
      n_fail++; $display("FAIL reset_sig: got %h expected 0000", signature);
    end
    n_checks++;
    if ({vec2, busy2, done2, err2, fev2, fevec2, sig2} !== 15'd0) begin
      n_fail++; $display("FAIL reset_small: got %b expected 0", {vec2, busy2, done2, err2, fev2, fevec2, sig2});
    end
  endtask

  task automatic test_binary;
    fault_mode = 2'd0;
    run_sweep(1'b0, 1'b0);
    n_checks++;
    if (busy_len !== 320) begin
      n_fail++; $display("FAIL bin_busy_len: got %0d expected 320", busy_len);
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++; $display("FAIL bin_hold: got %0d unstable cycles expected 0", hold_bad);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (seq[i] !== 4'(i)) begin
        n_fail++; $display("FAIL bin_vec[%0d]: got %0d expected %0d", i, seq[i], i);
      end
    end
    n_checks++;
    if (done_at_end !== 1'b1 || done_total !== 1) begin
      n_fail++; $display("FAIL bin_done: at_end %b count %0d expected 1 and 1", done_at_end, done_total);
    end
    n_checks++;
    if (err_cnt !== 5'd0 || fev !== 1'b0) begin
      n_fail++; $display("FAIL bin_err: got %0d/%b expected 0/0", err_cnt, fev);
    end
    n_checks++;
    if (signature !== 16'h3333) begin
      n_fail++; $display("FAIL bin_sig: got %h expected 3333", signature);
    end
    n_checks++;
    if (vec !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bin_idle: vec %0d busy %b expected 0 0", vec, busy);
    end
  endtask

  task automatic test_gray;
    logic [3:0] gexp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    fault_mode = 2'd0;
    run_sweep(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (seq[i] !== gexp[i]) begin
        n_fail++; $display("FAIL gray_vec[%0d]: got %h expected %h", i, seq[i], gexp[i]);
      end
    end
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if ($countones(seq[i] ^ seq[i-1]) != 1) begin
        n_fail++; $display("FAIL gray_step[%0d]: %h -> %h expected one toggled bit", i, seq[i-1], seq[i]);
      end
    end
    n_checks++;
    if (busy_len !== 320 || done_total !== 1) begin
      n_fail++; $display("FAIL gray_len: busy %0d done %0d expected 320 1", busy_len, done_total);
    end
    n_checks++;
    if (signature !== 16'h1E1E) begin
      n_fail++; $display("FAIL gray_sig: got %h expected 1e1e", signature);
    end
  endtask

  task automatic test_fault_binary;
    fault_mode = 2'd1;
    run_sweep(1'b0, 1'b0);
    n_checks++;
    if (err_cnt !== 5'd2 || fev !== 1'b1 || fevec !== 4'd5) begin
      n_fail++; $display("FAIL fault_bin: cnt %0d valid %b vec %0d expected 2 1 5", err_cnt, fev, fevec);
    end
    n_checks++;
    if (signature !== 16'h3333) begin
      n_fail++; $display("FAIL fault_bin_sig: got %h expected 3333", signature);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (err_cnt !== 5'd2 || fevec !== 4'd5 || signature !== 16'h3333) begin
      n_fail++; $display("FAIL fault_hold: cnt %0d vec %0d sig %h expected 2 5 3333", err_cnt, fevec, signature);
    end
  endtask

  task automatic test_fault_gray;
    fault_mode = 2'd2;
    run_sweep(1'b1, 1'b0);
    n_checks++;
    if (err_cnt !== 5'd2 || fev !== 1'b1 || fevec !== 4'd12) begin
      n_fail++; $display("FAIL fault_gray: cnt %0d valid %b vec %0d expected 2 1 12", err_cnt, fev, fevec);
    end
  endtask

  task automatic test_all_mismatch;
    fault_mode = 2'd3;
    run_sweep(1'b0, 1'b0);
    n_checks++;
    if (err_at_done !== 5'd16) begin
      n_fail++; $display("FAIL all_err_at_done: got %0d expected 16", err_at_done);
    end
    n_checks++;
    if (fev !== 1'b1 || fevec !== 4'd0) begin
      n_fail++; $display("FAIL all_first: valid %b vec %0d expected 1 0", fev, fevec);
    end
  endtask

  task automatic test_start_while_busy;
    fault_mode = 2'd0;
    run_sweep(1'b0, 1'b1);
    n_checks++;
    if (busy_len !== 320 || done_total !== 1) begin
      n_fail++; $display("FAIL poke_len: busy %0d done %0d expected 320 1", busy_len, done_total);
    end
    n_checks++;
    if (err_at_done !== 5'd0 || signature !== 16'h3333) begin
      n_fail++; $display("FAIL poke_result: cnt %0d sig %h expected 0 3333", err_at_done, signature);
    end
  endtask

  task automatic test_reset_abort;
    int t;
    int done_seen;
    fault_mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    gray_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (vec !== 4'd7 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (vec !== 4'd7 || err_cnt !== 5'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: vec %0d cnt %0d busy %b expected 7 1 1", vec, err_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vec, busy, done, err_cnt, fev, fevec, signature} !== 31'd0) begin
      n_fail++; $display("FAIL abort_zero: got %h expected 0", {vec, busy, done, err_cnt, fev, fevec, signature});
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done/busy cycles expected 0", done_seen);
    end
    fault_mode = 2'd0;
    run_sweep(1'b0, 1'b0);
    n_checks++;
    if (busy_len !== 320 || done_total !== 1 || err_cnt !== 5'd0 || signature !== 16'h3333) begin
      n_fail++; $display("FAIL abort_rerun: busy %0d done %0d cnt %0d sig %h expected 320 1 0 3333",
                         busy_len, done_total, err_cnt, signature);
    end
  endtask

  task automatic test_signature;
    int len;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    len = 0;
    while (busy2 === 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
    n_checks++;
    if (len !== 8 || done2 !== 1'b1) begin
      n_fail++; $display("FAIL small_len: busy %0d done %b expected 8 1", len, done2);
    end
    n_checks++;
    if (sig2 !== 4'hF || err2 !== 3'd0) begin
      n_fail++; $display("FAIL small_sig: sig %h cnt %0d expected f 0", sig2, err2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_binary;
    test_gray;
    test_fault_binary;
    test_fault_gray;
    test_all_mismatch;
    test_start_while_busy;
    test_reset_abort;
    test_signature;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
